addac_seq: RTL

Job sequencer for the `addac` accumulator datapath. It accepts a job: an operand count and an add/subtract mode. It then streams operands from a valid/ready source into `addac` by driving its `a`, `sel0` and `sel1` inputs cycle by cycle, and returns the final accumulated sum with a sticky carry flag. It sits between the operand producer and one `addac` instance, and is the only driver of that instance's inputs.

---
 rtl/addac_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/addac_seq.sv
// Job sequencer for the addac accumulator: streams a counted burst of
// operands into addac and returns the final sum with a sticky carry flag.
module addac_seq #(
    parameter int W    = 4,
    parameter int MAXN = 8,
    localparam int CW  = $clog2(MAXN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] n,
    input  logic          sub,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic [W-1:0]  a,
    output logic          sel0,
    output logic          sel1,
    input  logic [W-1:0]  s,
    input  logic          cout,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  res,
    output logic          ovf
);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ACC,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          sub_q;
    logic          acc_ovf_q;
    logic          chk_q;
    logic [W-1:0]  res_q;
    logic          ovf_q;
    logic          done_q;
    logic          busy_q;

    logic          hs;
    logic          last;
    logic          n_ok;
    logic [1:0]    op;

    assign in_ready = (state_q == FIRST) || (state_q == ACC);
    assign hs       = in_valid && in_ready;
    assign last     = (cnt_q == CW'(1));
    assign n_ok     = (n != '0) && (n <= CW'(MAXN));

    always_comb begin
        a  = '0;
        op = 2'b00;
        if (hs) begin
            a  = in_data;
            op = (state_q == FIRST) ? 2'b01 : {1'b1, sub_q};
        end
    end

    assign {sel1, sel0} = op;

    // chk_q marks the cycle after an add/sub, when addac's cout is fresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sub_q     <= 1'b0;
            acc_ovf_q <= 1'b0;
            chk_q     <= 1'b0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            chk_q  <= 1'b0;
            if (chk_q && cout) begin
                acc_ovf_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start && n_ok) begin
                        cnt_q   <= n;
                        sub_q   <= sub;
                        busy_q  <= 1'b1;
                        state_q <= FIRST;
                    end
                end
                FIRST: begin
                    if (hs) begin
                        cnt_q     <= cnt_q - CW'(1);
                        acc_ovf_q <= 1'b0;
                        state_q   <= last ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (hs) begin
                        cnt_q <= cnt_q - CW'(1);
                        chk_q <= 1'b1;
                        if (last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    res_q   <= s;
                    ovf_q   <= acc_ovf_q || (chk_q && cout);
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign res  = res_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule
